// File: rtl/upt_stream_arbiter.sv
// Round-robin arbiter sharing one streaming matrix engine between two requesters.
// Grants whole matrices; a tag FIFO sends each returned matrix back to the requester that sent it.
module upt_stream_arbiter #(
    parameter int unsigned SIZE       = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TAG_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s0_tdata,
    input  logic                  s0_tvalid,
    output logic                  s0_tready,
    input  logic [DATA_WIDTH-1:0] s1_tdata,
    input  logic                  s1_tvalid,
    output logic                  s1_tready,
    output logic [DATA_WIDTH-1:0] eng_in_tdata,
    output logic                  eng_in_tvalid,
    input  logic                  eng_in_tready,
    input  logic [DATA_WIDTH-1:0] eng_out_tdata,
    input  logic                  eng_out_tvalid,
    output logic                  eng_out_tready,
    output logic [DATA_WIDTH-1:0] m0_tdata,
    output logic                  m0_tvalid,
    input  logic                  m0_tready,
    output logic [DATA_WIDTH-1:0] m1_tdata,
    output logic                  m1_tvalid,
    input  logic                  m1_tready,
    output logic                  busy
);

    localparam int unsigned BEATS = SIZE * SIZE;
    localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PW    = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
    localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(TAG_DEPTH);

    typedef enum logic [1:0] {StIdle, StFwd0, StFwd1} state_t;

    state_t               r_state;
    logic [CW-1:0]        r_in_cnt;
    logic [CW-1:0]        r_out_cnt;
    logic                 r_last_grant;
    logic [TAG_DEPTH-1:0] r_tags;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [PW:0]          r_count;

    logic w_full;
    logic w_empty;
    logic w_head;
    logic w_grant;
    logic w_grant_id;
    logic w_in_fire;
    logic w_out_fire;
    logic w_pop;

    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_head     = r_tags[r_rd_ptr];
    assign w_grant    = (r_state == StIdle) && (s0_tvalid || s1_tvalid) && !w_full;
    // On contention the requester that did not win last time goes next.
    assign w_grant_id = (s0_tvalid && s1_tvalid) ? ~r_last_grant : s1_tvalid;
    assign w_in_fire  = eng_in_tvalid && eng_in_tready;
    assign w_out_fire = eng_out_tvalid && eng_out_tready;
    assign w_pop      = w_out_fire && (r_out_cnt == LAST_BEAT);
    assign busy       = (r_state != StIdle) || !w_empty;

    always_comb begin
        eng_in_tdata  = '0;
        eng_in_tvalid = 1'b0;
        s0_tready     = 1'b0;
        s1_tready     = 1'b0;
        unique case (r_state)
            StFwd0: begin
                eng_in_tdata  = s0_tdata;
                eng_in_tvalid = s0_tvalid;
                s0_tready     = eng_in_tready;
            end
            StFwd1: begin
                eng_in_tdata  = s1_tdata;
                eng_in_tvalid = s1_tvalid;
                s1_tready     = eng_in_tready;
            end
            default: ;
        endcase
    end

    always_comb begin
        m0_tdata       = '0;
        m0_tvalid      = 1'b0;
        m1_tdata       = '0;
        m1_tvalid      = 1'b0;
        eng_out_tready = 1'b0;
        if (!w_empty) begin
            if (w_head) begin
                m1_tdata       = eng_out_tdata;
                m1_tvalid      = eng_out_tvalid;
                eng_out_tready = m1_tready;
            end else begin
                m0_tdata       = eng_out_tdata;
                m0_tvalid      = eng_out_tvalid;
                eng_out_tready = m0_tready;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= StIdle;
            r_in_cnt     <= '0;
            r_last_grant <= 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_grant) begin
                        r_state      <= w_grant_id ? StFwd1 : StFwd0;
                        r_last_grant <= w_grant_id;
                    end
                end
                StFwd0, StFwd1: begin
                    if (w_in_fire) begin
                        if (r_in_cnt == LAST_BEAT) begin
                            r_in_cnt <= '0;
                            r_state  <= StIdle;
                        end else begin
                            r_in_cnt <= r_in_cnt + CW'(1);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_cnt <= '0;
            r_tags    <= '0;
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
        end else begin
            if (w_out_fire) begin
                r_out_cnt <= (r_out_cnt == LAST_BEAT) ? '0 : r_out_cnt + CW'(1);
            end
            if (w_grant) begin
                r_tags[r_wr_ptr] <= w_grant_id;
                r_wr_ptr         <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            // Push and pop in the same cycle leave the occupancy unchanged.
            if (w_grant && !w_pop) begin
                r_count <= r_count + (PW + 1)'(1);
            end else if (!w_grant && w_pop) begin
                r_count <= r_count - (PW + 1)'(1);
            end
        end
    end

endmodule

// File: doc/upt_stream_arbiter.md
Name: upt_stream_arbiter

Overview:
- Shares one matrix-transform engine (streaming SIZE×SIZE matrices, e.g. the upper-triangular engine) between two AXI-stream-style requesters.
- Grants the engine input to one requester for exactly one whole matrix (SIZE*SIZE beats), using round-robin between requesters.
- Records each grant in a tag FIFO, so each matrix the engine returns goes to the requester that sent it.
- Sits between the requester ports and the engine's in_t*/out_t* interface.

Parameters:
SIZE, 4, matrix dimension; one matrix = SIZE*SIZE beats
DATA_WIDTH, 32, width of every tdata bus
TAG_DEPTH, 4, number of matrices outstanding in the engine (power of 2, ≥2)

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  asynchronous, active-low reset
s0_tdata  in  DATA_WIDTH  requester 0 data
s0_tvalid  in  1  requester 0 valid
s0_tready  out  1  requester 0 ready
s1_tdata  in  DATA_WIDTH  requester 1 data
s1_tvalid  in  1  requester 1 valid
s1_tready  out  1  requester 1 ready
eng_in_tdata  out  DATA_WIDTH  data to engine
eng_in_tvalid  out  1  valid to engine
eng_in_tready  in  1  engine ready
eng_out_tdata  in  DATA_WIDTH  result from engine
eng_out_tvalid  in  1  engine result valid
eng_out_tready  out  1  ready to engine
m0_tdata  out  DATA_WIDTH  results to requester 0
m0_tvalid  out  1  requester 0 result valid
m0_tready  in  1  requester 0 result ready
m1_tdata  out  DATA_WIDTH  results to requester 1
m1_tvalid  out  1  requester 1 result valid
m1_tready  in  1  requester 1 result ready
busy  out  1  high when state≠IDLE or tag FIFO non-empty

Behaviour:
- Handshake: a beat transfers on a cycle where valid&&ready. Valid, once raised, is not dropped by this block until the beat transfers.
- Reset (rst=0, any time, including mid-matrix):
  - state=IDLE; in_cnt=out_cnt=0; tag FIFO emptied; last_grant=1 (requester 0 wins first).
  - Result: all tready/tvalid outputs=0, busy=0, tdata outputs=0. Partial matrices are discarded with no recovery.
- Input FSM, states IDLE, FWD0, FWD1:
  - IDLE → FWDx when sx_tvalid=1 and tag FIFO not full.
  - If both requesters are valid, grant the one ≠ last_grant.
  - On grant (registered): last_grant←x; push tag x into the FIFO.
  - The grant costs one cycle: no beat transfers in IDLE. All s*_tready=0 in IDLE.
  - In FWDx: eng_in_tdata=sx_tdata, eng_in_tvalid=sx_tvalid, sx_tready=eng_in_tready. The other requester's tready=0.
  - in_cnt increments per transferred beat. On beat SIZE*SIZE-1: in_cnt←0, state→IDLE.
  - eng_in_tvalid=0 and eng_in_tdata=0 outside FWD.
  - Throughput: SIZE*SIZE+1 cycles per matrix when valid/ready are held high.
- Tag FIFO: TAG_DEPTH entries, 1-bit tags, pointers wrap modulo TAG_DEPTH.
  - Simultaneous push and pop is legal; count is unchanged.
  - When full, grants stall in IDLE. Requesters see tready=0; nothing is dropped.
- Return path, combinational, selected by the head tag h:
  - Requires the FIFO to be non-empty.
  - mh_tdata=eng_out_tdata, mh_tvalid=eng_out_tvalid, eng_out_tready=mh_tready.
  - The other m port: tvalid=0, tdata=0.
  - When FIFO is empty: eng_out_tready=0 and both m tvalid=0.
  - out_cnt counts transferred result beats. On beat SIZE*SIZE-1: out_cnt←0, pop FIFO.
  - A pop and a same-cycle grant push coexist.
  - Backpressure on mh stalls only the return path; the input FSM continues while the FIFO is not full.
- Widths: counters are $clog2(SIZE*SIZE) bits, with explicit wrap at SIZE*SIZE-1 (no reliance on natural overflow).
- Latency: input path and return path are zero-cycle combinational pass-through once granted. The only added latency is the 1-cycle grant.

Test Plan:
- Single requester: rst low 2 cycles; s0 sends 16 beats 1..16, engine ready=1 → grant at cycle 1, beats on eng_in cycles 2–17. Engine echoes 16 results → all on m0; m1_tvalid never 1; busy falls after last m0 beat.
- Contention: s0 and s1 both valid from reset release → order s0, s1, s0, s1 over 4 matrices. Results return as 4 matrices alternating m0/m1, 16 beats each.
- FIFO full: TAG_DEPTH=4, engine out_tready held off, 5 matrices offered → 4 grants. 5th requester sees tready=0 until first result matrix completes, then grant the next cycle.
- Backpressure: m0_tready toggles every 2 cycles (low 1 cycle at beat 5) → eng_out_tready mirrors it; no lost or duplicated beats; data order is 1..16.
- Mid-matrix reset: rst low at in_cnt=7 of s1 matrix → next cycle all outputs 0, busy 0. After release, s0 is granted first if both are valid.
- Same-cycle push/pop: last result beat of matrix A coincides with grant of matrix C → FIFO count unchanged; C routes correctly.
